upsamp_sequencer: RTL and testbench
===================================

# upsamp_sequencer

Control block for the 64QAM upsampling chain. It loads the coefficient RAM of the upsampling filter, then runs it: accepts one 4-bit symbol per upsampling period, zero-stuffs the remaining phases, and flushes the filter taps at the end of a burst. It sits between the symbol source and configuration host on one side and the upsampling filter and output storage/validation stage on the other, and it generates the `valid_data` and `upsampling_rate` inputs of that storage stage.

## Interface
Parameters:
- `DATA_W`, 4: symbol width fed to the filter.
- `COEF_W`, 12: coefficient width.
- `NUM_TAPS`, 16: filter taps. Must be a power of two; it sets the coefficient count and the flush length.
- `RATE_W`, 9: width of the upsampling rate.
- `FILT_LAT`, 3: filter input-to-output latency in cycles, at least 1.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `cfg_load`, in, 1: one-cycle pulse that starts a coefficient load.
- `cfg_coef`, in, COEF_W: coefficient word.
- `cfg_valid`, in, 1: `cfg_coef` is valid.
- `cfg_ready`, out, 1: coefficient accepted. High throughout LOAD.
- `rate_in`, in, RATE_W: requested upsampling rate, sampled on RUN entry.
- `run_en`, in, 1: level. Start, or keep running, a burst.
- `sym_in`, in, DATA_W: input symbol.
- `sym_valid`, in, 1: `sym_in` is valid.
- `sym_ready`, out, 1: a symbol is taken this cycle if `sym_valid` is high.
- `filt_addr`, out, log2(NUM_TAPS): coefficient RAM address.
- `filt_coef`, out, COEF_W: coefficient write data.
- `filt_write_en`, out, 1: coefficient write strobe.
- `filt_data`, out, DATA_W: sample into the filter.
- `filt_data_en`, out, 1: `filt_data` is a live sample.
- `valid_data`, out, 1: the filter output is valid. Drives the storage stage.
- `upsampling_rate`, out, RATE_W: latched rate. Drives the storage stage.
- `busy`, out, 1: state is not IDLE.
- `coef_loaded`, out, 1: a full coefficient set has been written.
- `underrun`, out, 1: sticky. A symbol was missing at phase 0.
- `cfg_err`, out, 1: sticky. Illegal start or illegal load.

## Operation
State machine with four states: IDLE, LOAD, RUN, FLUSH.

- **IDLE**
  - `cfg_load` has priority over `run_en`. On `cfg_load`: go to LOAD, clear the tap counter, clear `coef_loaded`.
  - On `run_en`:
    - If `rate_in`==0 or `coef_loaded`==0, set `cfg_err` and stay in IDLE.
    - Otherwise latch `rate_in` into `upsampling_rate`, clear the phase counter and go to RUN.
- **LOAD**
  - `cfg_ready`=1.
  - Each cycle with `cfg_valid`=1, register `filt_write_en`=1, `filt_addr`=tap counter, `filt_coef`=`cfg_coef`, then increment the tap counter.
  - After write NUM_TAPS-1 is accepted: set `coef_loaded`=1 and return to IDLE.
  - Gaps in `cfg_valid` are allowed.
  - `run_en` is ignored in LOAD.
- **RUN**
  - The phase counter runs 0..`upsampling_rate`-1 and wraps to 0.
  - `sym_ready`=1 only at phase 0.
  - Phase 0:
    - With `sym_valid`: `filt_data`=`sym_in`.
    - Without `sym_valid`: `filt_data`=0 and set `underrun`. The phase still advances, so the output rate stays fixed.
  - Phases other than 0: `filt_data`=0 (zero stuffing).
  - `filt_data_en`=1 on every RUN cycle.
  - `run_en` low is evaluated only on the last phase (`upsampling_rate`-1). At that point, go to FLUSH with the flush counter at 0. A partial symbol period is never truncated.
  - A `cfg_load` pulse in RUN sets `cfg_err` and is otherwise ignored.
- **FLUSH**
  - Drive `filt_data`=0 with `filt_data_en`=1 for NUM_TAPS cycles, then go to IDLE.
  - `sym_ready`=0.
  - A `cfg_load` pulse in FLUSH sets `cfg_err` and is otherwise ignored.
- **Output validity:** `valid_data` is `filt_data_en` delayed by FILT_LAT registers. The delay line keeps shifting in every state.
- **Sticky flags:** `underrun` and `cfg_err` clear only on `rst`.
- **Width rules:**
  - The phase counter is RATE_W bits and its compare is exact, so rate 1 gives no stuffing.
  - The tap counter is log2(NUM_TAPS) bits and wraps naturally.

## Timing
- **Reset:** all outputs are 0, state is IDLE, and the delay line, counters and flags are cleared. This also applies to reset mid-burst: `valid_data` drops on the next cycle with no flush.
- **Registered outputs:** `filt_*` and `valid_data` are registered. `cfg_ready`, `sym_ready` and `busy` decode the current state and counter.
- **Symbol path:** a symbol accepted in cycle t appears on `filt_data` and `filt_data_en` in cycle t+1, with `valid_data` high in cycle t+1+FILT_LAT.
- **RUN entry:** `run_en` sampled high in IDLE in cycle t makes state RUN with `sym_ready`=1 in cycle t+1.
- **Coefficient path:** a coefficient accepted in cycle t gives `filt_write_en` in cycle t+1. For a gapless load, `coef_loaded` rises in cycle t0+NUM_TAPS, where t0 is the first accept.
- **Burst length:** K symbol periods produce exactly K·rate + NUM_TAPS cycles of `filt_data_en`.
- **Coincident events:** `cfg_load` and `run_en` in the same IDLE cycle go to LOAD, with no error.

## Test plan
- Reset, then load 16 coefficients 0x001..0x010 gaplessly -> `filt_addr` 0..15 with matching `filt_coef`, `coef_loaded`=1 exactly 16 cycles after the first accept, state back to IDLE.
- `rate_in`=4, run with symbols 0x3,0xA held valid, drop `run_en` -> `filt_data` is 3,0,0,0,A,0,0,0, then 16 zeros; `valid_data` high for 24 cycles, starting FILT_LAT cycles after the first `filt_data_en`.
- `rate_in`=4 with `sym_valid` low at the second phase 0 -> `filt_data`=0 on that phase, `underrun`=1, phase cadence unchanged, `underrun` persists after the burst.
- Illegal starts: `run_en` with `rate_in`=0, or before any load -> `cfg_err`=1, `busy` stays 0. `cfg_load` during RUN -> `cfg_err`=1, no `filt_write_en`.
- Edge cases:
  - `rate_in`=1: `sym_ready` is high every RUN cycle, with no zero stuffing.
  - `run_en` dropped at phase 1 of rate 4: two more stuffed cycles before FLUSH.
- Assert `rst` mid-RUN -> the next cycle shows all outputs 0 and IDLE, and `valid_data` stays 0 afterwards.

Source files
------------

// File: rtl/upsamp_sequencer.sv
// Control sequencer for the 64QAM upsampling filter: coefficient load, symbol
// zero-stuffing at the configured rate, tap flush and output-valid generation.
module upsamp_sequencer #(
    parameter int unsigned DATA_W   = 4,
    parameter int unsigned COEF_W   = 12,
    parameter int unsigned NUM_TAPS = 16,
    parameter int unsigned RATE_W   = 9,
    parameter int unsigned FILT_LAT = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_load,
    input  logic [COEF_W-1:0]           cfg_coef,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [RATE_W-1:0]           rate_in,
    input  logic                        run_en,
    input  logic [DATA_W-1:0]           sym_in,
    input  logic                        sym_valid,
    output logic                        sym_ready,
    output logic [$clog2(NUM_TAPS)-1:0] filt_addr,
    output logic [COEF_W-1:0]           filt_coef,
    output logic                        filt_write_en,
    output logic [DATA_W-1:0]           filt_data,
    output logic                        filt_data_en,
    output logic                        valid_data,
    output logic [RATE_W-1:0]           upsampling_rate,
    output logic                        busy,
    output logic                        coef_loaded,
    output logic                        underrun,
    output logic                        cfg_err
);

    localparam int unsigned AddrW = $clog2(NUM_TAPS);
    localparam logic [AddrW-1:0] TapLast = AddrW'(NUM_TAPS - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StFlush} state_e;

    state_e              state_q, state_d;
    logic [AddrW-1:0]    tap_q, tap_d;
    logic [AddrW-1:0]    flush_q, flush_d;
    logic [RATE_W-1:0]   phase_q, phase_d;
    logic [RATE_W-1:0]   rate_q, rate_d;
    logic                loaded_q, loaded_d;
    logic                underrun_q, underrun_d;
    logic                cfg_err_q, cfg_err_d;

    logic [AddrW-1:0]    filt_addr_q, filt_addr_d;
    logic [COEF_W-1:0]   filt_coef_q, filt_coef_d;
    logic                filt_write_en_q, filt_write_en_d;
    logic [DATA_W-1:0]   filt_data_q, filt_data_d;
    logic                filt_data_en_q, filt_data_en_d;
    logic [FILT_LAT-1:0] vld_q;

    logic phase_zero;
    logic last_phase;

    assign phase_zero = (phase_q == '0);
    assign last_phase = (phase_q == rate_q - RATE_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            tap_q           <= '0;
            flush_q         <= '0;
            phase_q         <= '0;
            rate_q          <= '0;
            loaded_q        <= 1'b0;
            underrun_q      <= 1'b0;
            cfg_err_q       <= 1'b0;
            filt_addr_q     <= '0;
            filt_coef_q     <= '0;
            filt_write_en_q <= 1'b0;
            filt_data_q     <= '0;
            filt_data_en_q  <= 1'b0;
            vld_q           <= '0;
        end else begin
            state_q         <= state_d;
            tap_q           <= tap_d;
            flush_q         <= flush_d;
            phase_q         <= phase_d;
            rate_q          <= rate_d;
            loaded_q        <= loaded_d;
            underrun_q      <= underrun_d;
            cfg_err_q       <= cfg_err_d;
            filt_addr_q     <= filt_addr_d;
            filt_coef_q     <= filt_coef_d;
            filt_write_en_q <= filt_write_en_d;
            filt_data_q     <= filt_data_d;
            filt_data_en_q  <= filt_data_en_d;
            // Models the filter latency; shifts in every state.
            vld_q           <= FILT_LAT'({vld_q, filt_data_en_q});
        end
    end

    always_comb begin
        state_d    = state_q;
        tap_d      = tap_q;
        flush_d    = flush_q;
        phase_d    = phase_q;
        rate_d     = rate_q;
        loaded_d   = loaded_q;
        underrun_d = underrun_q;
        cfg_err_d  = cfg_err_q;
        case (state_q)
            StIdle: begin
                if (cfg_load) begin
                    state_d  = StLoad;
                    tap_d    = '0;
                    loaded_d = 1'b0;
                end else if (run_en) begin
                    if (rate_in == '0 || !loaded_q) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        rate_d  = rate_in;
                        phase_d = '0;
                        state_d = StRun;
                    end
                end
            end
            StLoad: begin
                if (cfg_valid) begin
                    tap_d = tap_q + AddrW'(1);
                    if (tap_q == TapLast) begin
                        loaded_d = 1'b1;
                        state_d  = StIdle;
                    end
                end
            end
            StRun: begin
                if (cfg_load) cfg_err_d = 1'b1;
                if (phase_zero && !sym_valid) underrun_d = 1'b1;
                // run_en is only honoured at the end of a full symbol period.
                if (last_phase) begin
                    phase_d = '0;
                    if (!run_en) begin
                        state_d = StFlush;
                        flush_d = '0;
                    end
                end else begin
                    phase_d = phase_q + RATE_W'(1);
                end
            end
            StFlush: begin
                if (cfg_load) cfg_err_d = 1'b1;
                flush_d = flush_q + AddrW'(1);
                if (flush_q == TapLast) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cfg_ready       = (state_q == StLoad);
        sym_ready       = (state_q == StRun) && phase_zero;
        busy            = (state_q != StIdle);
        filt_addr_d     = filt_addr_q;
        filt_coef_d     = filt_coef_q;
        filt_write_en_d = 1'b0;
        filt_data_d     = '0;
        filt_data_en_d  = 1'b0;
        case (state_q)
            StLoad: begin
                if (cfg_valid) begin
                    filt_write_en_d = 1'b1;
                    filt_addr_d     = tap_q;
                    filt_coef_d     = cfg_coef;
                end
            end
            StRun: begin
                filt_data_en_d = 1'b1;
                if (phase_zero && sym_valid) filt_data_d = sym_in;
            end
            StFlush: filt_data_en_d = 1'b1;
            default: ;
        endcase
    end

    assign filt_addr       = filt_addr_q;
    assign filt_coef       = filt_coef_q;
    assign filt_write_en   = filt_write_en_q;
    assign filt_data       = filt_data_q;
    assign filt_data_en    = filt_data_en_q;
    assign valid_data      = vld_q[FILT_LAT-1];
    assign upsampling_rate = rate_q;
    assign coef_loaded     = loaded_q;
    assign underrun        = underrun_q;
    assign cfg_err         = cfg_err_q;

endmodule

// File: tb/tb_upsamp_sequencer.sv
// Directed bench for upsamp_sequencer: coefficient and sample scoreboards fed at
// stimulus time, popped as the DUT strobes filt_write_en / filt_data_en.
module tb_upsamp_sequencer;

    localparam int DATA_W   = 4;
    localparam int COEF_W   = 12;
    localparam int NUM_TAPS = 16;
    localparam int RATE_W   = 9;
    localparam int FILT_LAT = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                cfg_load;
    logic [COEF_W-1:0]   cfg_coef;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [RATE_W-1:0]   rate_in;
    logic                run_en;
    logic [DATA_W-1:0]   sym_in;
    logic                sym_valid;
    logic                sym_ready;
    logic [3:0]          filt_addr;
    logic [COEF_W-1:0]   filt_coef;
    logic                filt_write_en;
    logic [DATA_W-1:0]   filt_data;
    logic                filt_data_en;
    logic                valid_data;
    logic [RATE_W-1:0]   upsampling_rate;
    logic                busy;
    logic                coef_loaded;
    logic                underrun;
    logic                cfg_err;

    always #5 clk = ~clk;

    upsamp_sequencer #(
        .DATA_W  (DATA_W),
        .COEF_W  (COEF_W),
        .NUM_TAPS(NUM_TAPS),
        .RATE_W  (RATE_W),
        .FILT_LAT(FILT_LAT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_load       (cfg_load),
        .cfg_coef       (cfg_coef),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .rate_in        (rate_in),
        .run_en         (run_en),
        .sym_in         (sym_in),
        .sym_valid      (sym_valid),
        .sym_ready      (sym_ready),
        .filt_addr      (filt_addr),
        .filt_coef      (filt_coef),
        .filt_write_en  (filt_write_en),
        .filt_data      (filt_data),
        .filt_data_en   (filt_data_en),
        .valid_data     (valid_data),
        .upsampling_rate(upsampling_rate),
        .busy           (busy),
        .coef_loaded    (coef_loaded),
        .underrun       (underrun),
        .cfg_err        (cfg_err)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] wq[$];
    logic [3:0]  dq[$];
    bit          sb_en = 1'b1;
    int          ecnt, efirst, vcnt, vfirst, vlast;
    logic [3:0]  sym_tab[4];
    bit          vld_tab[4];
    bit          exp_err, exp_under;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {cfg_ready, sym_ready, filt_addr, filt_coef, filt_write_en, filt_data,
                filt_data_en, valid_data, upsampling_rate, busy, coef_loaded, underrun, cfg_err};
    endfunction

    // Advance to the next falling edge and run the scoreboards there.
    task automatic tick();
        logic [15:0] e;
        @(negedge clk);
        cyc++;
        if (wq.size() == 0) chk("stray_write", filt_write_en, 0);
        else if (filt_write_en) begin
            e = wq.pop_front();
            chk("write_addr_coef", {filt_addr, filt_coef}, e);
        end
        if (sb_en) begin
            if (dq.size() == 0) chk("stray_data_en", filt_data_en, 0);
            else if (filt_data_en) chk("filt_data", filt_data, dq.pop_front());
        end
        if (filt_data_en) begin
            ecnt++;
            if (efirst < 0) efirst = cyc;
        end
        if (valid_data) begin
            vcnt++;
            if (vfirst < 0) vfirst = cyc;
            vlast = cyc;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_err   = 1'b0;
        exp_under = 1'b0;
    endtask

    task automatic load_coefs(input bit with_run);
        cfg_load = 1'b1;
        run_en   = with_run;
        rate_in  = RATE_W'(4);
        tick();
        cfg_load = 1'b0;
        run_en   = 1'b0;
        chk("load_cfg_ready", cfg_ready, 1);
        chk("load_coef_loaded_clr", coef_loaded, 0);
        for (int i = 0; i < NUM_TAPS; i++) begin
            if (i == 5) begin
                cfg_valid = 1'b0;
                tick();
                chk("load_gap_ready", cfg_ready, 1);
            end
            cfg_valid = 1'b1;
            cfg_coef  = COEF_W'(i + 1);
            wq.push_back({4'(i), 12'(i + 1)});
            tick();
            chk("coef_loaded_timing", coef_loaded, (i == NUM_TAPS - 1));
        end
        cfg_valid = 1'b0;
        chk("load_done_busy", busy, 0);
        chk("load_done_ready", cfg_ready, 0);
        tick();
        chk("load_queue_empty", wq.size(), 0);
        chk("load_cfg_err", cfg_err, exp_err);
    endtask

    task automatic run_burst(input int rate, input int periods, input int drop, input bit inj);
        int c0, total;
        total = periods * rate + NUM_TAPS;
        for (int p = 0; p < periods; p++)
            for (int ph = 0; ph < rate; ph++)
                dq.push_back((ph == 0 && vld_tab[p]) ? sym_tab[p] : 4'h0);
        for (int i = 0; i < NUM_TAPS; i++) dq.push_back(4'h0);
        ecnt = 0; efirst = -1; vcnt = 0; vfirst = -1; vlast = -1;
        c0      = cyc;
        rate_in = RATE_W'(rate);
        run_en  = 1'b1;
        tick();
        chk("run_entry_busy", busy, 1);
        chk("rate_latched", upsampling_rate, rate);
        for (int p = 0; p < periods; p++) begin
            for (int ph = 0; ph < rate; ph++) begin
                chk("sym_ready_phase", sym_ready, (ph == 0));
                if (ph == 0) begin
                    sym_in    = sym_tab[p];
                    sym_valid = vld_tab[p];
                    if (!vld_tab[p]) exp_under = 1'b1;
                end
                if (p == periods - 1 && ph == drop) run_en = 1'b0;
                cfg_load = inj && p == 0 && ph == 1;
                tick();
            end
        end
        cfg_load  = 1'b0;
        sym_valid = 1'b0;
        chk("flush_sym_ready", sym_ready, 0);
        chk("flush_busy", busy, 1);
        repeat (NUM_TAPS + FILT_LAT + 2) tick();
        chk("burst_idle", busy, 0);
        chk("burst_queue_empty", dq.size(), 0);
        chk("en_count", ecnt, total);
        chk("en_first", efirst, c0 + 2);
        chk("valid_count", vcnt, total);
        chk("valid_first", vfirst, c0 + 2 + FILT_LAT);
        chk("valid_last", vlast, c0 + 1 + FILT_LAT + total);
        chk("underrun_flag", underrun, exp_under);
        chk("cfg_err_flag", cfg_err, exp_err);
    endtask

    initial begin
        rst = 1'b1; cfg_load = 1'b0; cfg_coef = '0; cfg_valid = 1'b0;
        rate_in = '0; run_en = 1'b0; sym_in = '0; sym_valid = 1'b0;
        exp_err = 1'b0; exp_under = 1'b0;
        repeat (2) tick();
        chk("reset_outs", all_outs(), 0);
        rst = 1'b0;

        // Start before any coefficients are loaded.
        rate_in = RATE_W'(4);
        run_en  = 1'b1;
        tick();
        run_en = 1'b0;
        chk("no_coef_err", cfg_err, 1);
        chk("no_coef_busy", busy, 0);
        tick();
        chk("no_coef_still_idle", busy, 0);
        do_reset();
        chk("reset_clears_err", cfg_err, 0);

        load_coefs(1'b0);

        sym_tab[0] = 4'h3; sym_tab[1] = 4'hA; vld_tab[0] = 1'b1; vld_tab[1] = 1'b1;
        run_burst(4, 2, 0, 1'b0);

        chk("underrun_before", underrun, 0);
        vld_tab[1] = 1'b0;
        run_burst(4, 2, 0, 1'b0);

        sym_tab[0] = 4'h5; sym_tab[1] = 4'h6; sym_tab[2] = 4'h7;
        vld_tab[0] = 1'b1; vld_tab[1] = 1'b1; vld_tab[2] = 1'b1;
        run_burst(1, 3, 0, 1'b0);

        sym_tab[0] = 4'hC; sym_tab[1] = 4'h9;
        run_burst(4, 2, 1, 1'b0);

        // Reload with run_en coincident, then a cfg_load pulse mid-burst.
        load_coefs(1'b1);
        exp_err = 1'b1;
        run_burst(4, 2, 3, 1'b1);

        do_reset();
        load_coefs(1'b0);
        rate_in = '0;
        run_en  = 1'b1;
        tick();
        run_en = 1'b0;
        chk("rate0_err", cfg_err, 1);
        chk("rate0_busy", busy, 0);

        // Reset in the middle of a burst.
        sb_en     = 1'b0;
        rate_in   = RATE_W'(4);
        run_en    = 1'b1;
        sym_in    = 4'h5;
        sym_valid = 1'b1;
        repeat (8) tick();
        chk("midrun_valid", valid_data, 1);
        rst = 1'b1;
        tick();
        chk("midrun_reset_outs", all_outs(), 0);
        rst = 1'b0; run_en = 1'b0; sym_valid = 1'b0;
        repeat (10) begin
            tick();
            chk("post_reset_valid", valid_data, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
